// File: rtl/uart_led_ctrl_pkg.sv
// Shared definitions for the UART LED command engine.
// Holds the opcodes, the reply byte codes and the FSM state encoding.
// Also holds a helper that checks a channel index against the channel count.
package uart_led_ctrl_pkg;

  localparam logic [3:0] OP_SET  = 4'h1;
  localparam logic [3:0] OP_GET  = 4'h2;
  localparam logic [3:0] OP_STAT = 4'h3;

  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARG   = 2'd1,
    ST_REPLY = 2'd2
  } state_t;

  // True when a 4-bit channel field addresses an existing LED channel.
  function automatic logic ch_ok(input logic [3:0] ch, input int num_leds);
    return int'(ch) < num_leds;
  endfunction

endpackage

// File: rtl/uart_led_ctrl_led_pwm_chan.sv
// One PWM LED channel: duty register plus a registered compare against the shared counter.
// Latency: a duty write affects led on the same edge it is written (write data bypasses the register).
// No backpressure; all-ones duty holds the LED on without a gap at the counter wrap.
module led_pwm_chan #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                wr_en,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic [PWM_BITS-1:0] cnt,
  output logic [PWM_BITS-1:0] duty,
  output logic                led
);

  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                led_q, led_d;

  // Next duty and LED level; the fresh duty is used so a write shows on led one cycle later.
  always_comb begin
    duty_d = wr_en ? wr_duty : duty_q;
    led_d  = (duty_d == '1) || (cnt < duty_d);
  end

  // Duty and LED registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      duty_q <= '0;
      led_q  <= 1'b0;
    end else begin
      duty_q <= duty_d;
      led_q  <= led_d;
    end
  end

  assign duty = duty_q;
  assign led  = led_q;

endmodule

// File: rtl/uart_led_ctrl.sv
// Byte command engine: UART rx bytes set/read PWM LED duties and read switch status.
// Latency: tx_valid rises one cycle after the final command byte; led follows a duty write one cycle later.
// Backpressure: a reply is held until tx_ready; rx bytes arriving during a reply are dropped and flag err_ovr.
// Build option: define UART_LED_CTRL_ACK_EN to answer each completed SET with 0xAA.
module uart_led_ctrl
  import uart_led_ctrl_pkg::*;
#(
  parameter int NUM_LEDS   = 8,
  parameter int PWM_BITS   = 8,
  parameter int PWM_DIV    = 64,
  parameter int RX_TIMEOUT = 50000,
  parameter int IN_W       = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [IN_W-1:0]     in_status,
  output logic [NUM_LEDS-1:0] led,
  output logic                err_ovr
);

  localparam int TMR_W = $clog2(RX_TIMEOUT + 1);
  localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  state_t              state_q, state_d;
  logic [3:0]          ch_q, ch_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                err_q, err_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  logic                duty_wr;
  logic                tick;
  logic [PWM_BITS-1:0] rd_duty;
  logic [PWM_BITS-1:0] duty_all [NUM_LEDS];
  logic [NUM_LEDS-1:0] wr_en_vec;
  logic [3:0]          rx_op, rx_ch;

  assign rx_op = rx_data[7:4];
  assign rx_ch = rx_data[3:0];

  // Prescaler divides clk down to PWM ticks; the counter wraps naturally at all-ones.
  always_comb begin
    tick  = (pre_q == PRE_W'(PWM_DIV - 1));
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
  end

  // Duty readback mux for GET, addressed by the channel field of the incoming byte.
  always_comb begin
    rd_duty = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (rx_ch == 4'(i)) rd_duty = duty_all[i];
    end
  end

  // Command FSM: decode in IDLE, collect the duty byte in ARG, hold the reply in REPLY.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    err_d     = err_q;
    duty_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_op == OP_SET && ch_ok(rx_ch, NUM_LEDS)) begin
            state_d = ST_ARG;
            ch_d    = rx_ch;
            timer_d = '0;
          end else begin
            state_d = ST_REPLY;
            if (rx_op == OP_GET && ch_ok(rx_ch, NUM_LEDS))
              tx_data_d = 8'(rd_duty) << (8 - PWM_BITS);
            else if (rx_op == OP_STAT)
              tx_data_d = 8'(in_status);
            else
              tx_data_d = NAK_BYTE;
          end
        end
      end
      ST_ARG: begin
        if (rx_valid) begin
          duty_wr = 1'b1;
`ifdef UART_LED_CTRL_ACK_EN
          state_d   = ST_REPLY;
          tx_data_d = ACK_BYTE;
`else
          state_d   = ST_IDLE;
`endif
        end else if (timer_q == TMR_W'(RX_TIMEOUT)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      ST_REPLY: begin
        // The host may not stream bytes into a pending reply; they are lost.
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and PWM timebase registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      timer_q   <= '0;
      tx_data_q <= '0;
      err_q     <= 1'b0;
      pre_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      err_q     <= err_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
      assign wr_en_vec[gi] = duty_wr && (ch_q == 4'(gi));
      led_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (wr_en_vec[gi]),
        .wr_duty (rx_data[7 -: PWM_BITS]),
        .cnt     (cnt_q),
        .duty    (duty_all[gi]),
        .led     (led[gi])
      );
    end
  endgenerate

  // tx_valid decodes straight from the state flop so reset clears it without a clock.
  assign tx_valid = (state_q == ST_REPLY);
  assign tx_data  = tx_data_q;
  assign err_ovr  = err_q;

endmodule

// File: tb/tb_uart_led_ctrl.sv
module tb_uart_led_ctrl;

  localparam int NUM_LEDS   = 8;
  localparam int PWM_BITS   = 8;
  localparam int PWM_DIV    = 2;
  localparam int RX_TIMEOUT = 200;
  localparam int IN_W       = 8;
  // One full PWM period in clk cycles.
  localparam int PERIOD     = 256 * PWM_DIV;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic                rx_valid = 1'b0;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready = 1'b0;
  logic [IN_W-1:0]     in_status = '0;
  logic [NUM_LEDS-1:0] led;
  logic                err_ovr;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  uart_led_ctrl #(
    .NUM_LEDS   (NUM_LEDS),
    .PWM_BITS   (PWM_BITS),
    .PWM_DIV    (PWM_DIV),
    .RX_TIMEOUT (RX_TIMEOUT),
    .IN_W       (IN_W)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .in_status (in_status),
    .led       (led),
    .err_ovr   (err_ovr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one byte for one cycle; returns at the falling edge after it was taken.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Call right after the final command byte: check the reply, then complete the handshake.
  task automatic reply(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, tx_valid, 1);
    chk({tag, "_dat"}, tx_data, exp);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk({tag, "_done"}, tx_valid, 0);
  endtask

  task automatic set_duty(input logic [3:0] ch, input logic [7:0] d);
    send({4'h1, ch});
    chk("set_in_arg_novld", tx_valid, 0);
    send(d);
`ifdef UART_LED_CTRL_ACK_EN
    reply("set_ack", 8'hAA);
`else
    chk("set_noack", tx_valid, 0);
`endif
  endtask

  task automatic count_high(input int idx, output int cnt);
    cnt = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (led[idx]) cnt++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Reset held with rx traffic: outputs stay quiet.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_led", led, 0);
      chk("rst_tx_vld", tx_valid, 0);
      chk("rst_tx_dat", tx_data, 0);
      chk("rst_err", err_ovr, 0);
      rx_valid = 1'b1;
      rx_data  = (i % 2 == 1) ? 8'hFF : 8'h13;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    resetn   = 1'b1;
    @(negedge clk);
    chk("post_rst_led", led, 0);
    chk("post_rst_vld", tx_valid, 0);
    chk("post_rst_err", err_ovr, 0);

    // SET ch3 duties: half, zero, full.
    set_duty(4'h3, 8'h80);
    repeat (2) @(negedge clk);
    count_high(3, n);
    chk("duty80_high", n, PERIOD / 2);
    chk("duty80_others", led & 8'hF7, 0);

    set_duty(4'h3, 8'h00);
    repeat (2) @(negedge clk);
    count_high(3, n);
    chk("duty00_high", n, 0);

    set_duty(4'h3, 8'hFF);
    chk("dutyFF_immediate", led[3], 1);
    count_high(3, n);
    chk("dutyFF_high", n, PERIOD);

    // GET held under backpressure.
    set_duty(4'h2, 8'h40);
    send(8'h22);
    chk("get_latency", tx_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("get_hold_vld", tx_valid, 1);
      chk("get_hold_dat", tx_data, 8'h40);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("get_release", tx_valid, 0);

    // STAT.
    in_status = 8'hA5;
    send(8'h30);
    reply("stat", 8'hA5);

    // NAKs: out-of-range channel SET and unknown opcode; duties untouched.
    send(8'h1F);
    reply("nak_ch", 8'hEE);
    send(8'h70);
    reply("nak_op", 8'hEE);
    send(8'h22);
    reply("get2_after_nak", 8'h40);
    send(8'h23);
    reply("get3_after_nak", 8'hFF);
    send(8'h2F);
    reply("nak_get_ch", 8'hEE);
    chk("err_clean", err_ovr, 0);

    // ACK build option on a fresh SET.
    set_duty(4'h0, 8'h55);
    send(8'h20);
    reply("get0", 8'h55);

    // ARG timeout.
    send(8'h11);
    repeat (RX_TIMEOUT - 5) @(negedge clk);
    chk("to_before_err", err_ovr, 0);
    chk("to_before_vld", tx_valid, 0);
    repeat (10) @(negedge clk);
    chk("to_after_err", err_ovr, 1);
    send(8'h21);
    reply("get1_after_to", 8'h00);

    // Reset clears sticky error and duties.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("rst2_err", err_ovr, 0);
    send(8'h23);
    reply("get3_after_rst", 8'h00);

    // Overrun while a reply is pending.
    in_status = 8'h3C;
    send(8'h30);
    chk("ovr_pend_vld", tx_valid, 1);
    send(8'h13);
    chk("ovr_err", err_ovr, 1);
    chk("ovr_dat_held", tx_data, 8'h3C);
    reply("ovr_reply", 8'h3C);
    send(8'h23);
    reply("ovr_get3", 8'h00);

    // Overrun on the handshake cycle itself.
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    send(8'h30);
    tx_ready = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h13;
    @(negedge clk);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    chk("hs_ovr_err", err_ovr, 1);
    chk("hs_ovr_vld", tx_valid, 0);
    send(8'h23);
    reply("hs_ovr_get3", 8'h00);

    // Asynchronous reset mid-reply drops tx_valid without a clock edge.
    send(8'h30);
    chk("async_pre_vld", tx_valid, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_vld", tx_valid, 0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("async_no_reply", tx_valid, 0);

    // Reset mid-command returns to IDLE.
    send(8'h12);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    send(8'h22);
    reply("midcmd_get2", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
